// File: rtl/kv_line_fill_if.sv
`default_nettype none
// ============================================================================
// Module      : kv_line_fill_if
// Description : Fetch-request, line-return and memory-read signals of the
//               KVCache line-fill engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface kv_line_fill_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 4
);
    logic [ADDR_WIDTH-1:0]                 i_req_addr;
    logic                                  i_req_valid;
    logic                                  o_req_ready;
    logic [LINE_SIZE-1:0][DATA_WIDTH-1:0]  o_line_data;
    logic [ADDR_WIDTH-1:0]                 o_line_addr;
    logic                                  o_line_valid;
    logic                                  i_line_ready;
    logic [ADDR_WIDTH-1:0]                 o_mem_addr;
    logic                                  o_mem_valid;
    logic                                  i_mem_ready;
    logic [DATA_WIDTH-1:0]                 i_mem_rdata;
    logic                                  i_mem_rvalid;

    // Engine side
    modport slave (
        input  i_req_addr, i_req_valid, i_line_ready,
               i_mem_ready, i_mem_rdata, i_mem_rvalid,
        output o_req_ready, o_line_data, o_line_addr, o_line_valid,
               o_mem_addr, o_mem_valid
    );

    // Cache and memory side
    modport master (
        output i_req_addr, i_req_valid, i_line_ready,
               i_mem_ready, i_mem_rdata, i_mem_rvalid,
        input  o_req_ready, o_line_data, o_line_addr, o_line_valid,
               o_mem_addr, o_mem_valid
    );
endinterface
`default_nettype wire

// File: rtl/kv_line_fill.sv
`default_nettype none
// ============================================================================
// Module      : kv_line_fill
// Description : Fetches one cache line as LINE_SIZE pipelined word reads and
//               returns the assembled line on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module kv_line_fill #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 4
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst,
    kv_line_fill_if.slave     bus
);
    localparam int c_CNT_W = $clog2(LINE_SIZE) + 1;
    localparam int c_IDX_W = $clog2(LINE_SIZE);

    localparam logic [c_CNT_W-1:0]    c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]    c_LAST_CNT  = c_CNT_W'(LINE_SIZE - 1);
    localparam logic [c_CNT_W-1:0]    c_FULL_CNT  = c_CNT_W'(LINE_SIZE);
    localparam logic [ADDR_WIDTH-1:0] c_WORD_STEP = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] c_OFF_MASK  = ADDR_WIDTH'(LINE_SIZE * 4 - 1);

    // FETCH is split into ISSUE (reads still to send) and DRAIN (all sent)
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]                            r_state;
    logic [c_CNT_W-1:0]                    r_issue_cnt;
    logic [c_CNT_W-1:0]                    r_recv_cnt;
    logic                                  r_req_ready;
    logic                                  r_mem_valid;
    logic [ADDR_WIDTH-1:0]                 r_mem_addr;
    logic                                  r_line_valid;
    logic [ADDR_WIDTH-1:0]                 r_line_addr;
    logic [LINE_SIZE-1:0][DATA_WIDTH-1:0]  r_line_data;

    logic [ADDR_WIDTH-1:0] w_base;
    logic                  w_fetching;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_recv;
    logic                  w_last_recv;
    logic [c_IDX_W-1:0]    w_recv_idx;

    assign w_base       = bus.i_req_addr & ~c_OFF_MASK;
    assign w_fetching   = (r_state == c_ST_ISSUE) || (r_state == c_ST_DRAIN);
    assign w_issue      = r_mem_valid && bus.i_mem_ready;
    assign w_last_issue = w_issue && (r_issue_cnt == c_LAST_CNT);
    assign w_recv       = w_fetching && bus.i_mem_rvalid && (r_recv_cnt != c_FULL_CNT);
    assign w_last_recv  = w_recv && (r_recv_cnt == c_LAST_CNT);
    assign w_recv_idx   = r_recv_cnt[c_IDX_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= c_ST_IDLE;
            r_issue_cnt  <= '0;
            r_recv_cnt   <= '0;
            r_req_ready  <= 1'b1;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_line_valid <= 1'b0;
            r_line_addr  <= '0;
            r_line_data  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.i_req_valid) begin
                        r_req_ready <= 1'b0;
                        r_line_addr <= w_base;
                        r_mem_addr  <= w_base;
                        r_mem_valid <= 1'b1;
                        r_issue_cnt <= '0;
                        r_recv_cnt  <= '0;
                        r_state     <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE, c_ST_DRAIN: begin
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt + c_CNT_ONE;
                        if (w_last_issue) begin
                            r_mem_valid <= 1'b0;
                        end else begin
                            r_mem_addr <= r_mem_addr + c_WORD_STEP;
                        end
                    end
                    if (w_recv) begin
                        r_line_data[w_recv_idx] <= bus.i_mem_rdata;
                        r_recv_cnt              <= r_recv_cnt + c_CNT_ONE;
                    end
                    if (w_last_recv) begin
                        r_mem_valid  <= 1'b0;
                        r_line_valid <= 1'b1;
                        r_state      <= c_ST_DONE;
                    end else if (w_last_issue) begin
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DONE: begin
                    if (bus.i_line_ready) begin
                        r_line_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_req_ready  = r_req_ready;
    assign bus.o_mem_valid  = r_mem_valid;
    assign bus.o_mem_addr   = r_mem_addr;
    assign bus.o_line_valid = r_line_valid;
    assign bus.o_line_addr  = r_line_addr;
    assign bus.o_line_data  = r_line_data;

endmodule
`default_nettype wire

// File: tb/tb_kv_line_fill.sv
`default_nettype none
// ============================================================================
// Module      : tb_kv_line_fill
// Description : Scoreboard bench for kv_line_fill with an in-order memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_kv_line_fill;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kv_line_fill_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_SIZE(LS)) bus ();

    kv_line_fill #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_SIZE(LS)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t         rsp_q[$];
    logic [31:0]  exp_addr_q[$];
    logic [127:0] exp_line_q[$];
    logic [31:0]  exp_base_q[$];
    bit           rdy_q[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          n_issue = 0;
    bit          var_lat = 1'b0;
    bit          spur = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_line(input logic [31:0] base);
        logic [127:0] l;
        logic [31:0]  a;
        l = '0;
        for (int i = 0; i < LS; i++) begin
            a = base + 32'(4 * i);
            l[32*i +: 32] = a;
        end
        return l;
    endfunction

    // Drives memory inputs for the current cycle, then advances one clock.
    task automatic step();
        rsp_t        r;
        int          d;
        logic [31:0] e;
        if (prev_stall) begin
            check("stall_valid", 128'(bus.o_mem_valid), 128'(1));
            check("stall_addr", 128'(bus.o_mem_addr), 128'(prev_addr));
        end
        bus.i_mem_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
        prev_stall = !rst && bus.o_mem_valid && !bus.i_mem_ready;
        prev_addr  = bus.o_mem_addr;
        if (spur) begin
            bus.i_mem_rvalid = 1'b1;
            bus.i_mem_rdata  = 32'hDEAD_BEEF;
        end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            r = rsp_q.pop_front();
            bus.i_mem_rvalid = 1'b1;
            bus.i_mem_rdata  = r.data;
        end else begin
            bus.i_mem_rvalid = 1'b0;
            bus.i_mem_rdata  = $urandom();
        end
        if (rst) begin
            rsp_q.delete();
            exp_addr_q.delete();
            exp_line_q.delete();
            exp_base_q.delete();
            last_due = 0;
        end else if (bus.o_mem_valid && bus.i_mem_ready) begin
            n_issue++;
            if (exp_addr_q.size() == 0) begin
                check("extra_issue", 128'(exp_addr_q.size()), 128'(1));
            end else begin
                e = exp_addr_q.pop_front();
                check("issue_addr", 128'(bus.o_mem_addr), 128'(e));
            end
            d = cyc + 1 + (var_lat ? int'($urandom_range(0, 3)) : 0);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            r.data = bus.o_mem_addr;
            r.due  = d;
            rsp_q.push_back(r);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic start(input logic [31:0] addr, input bit hold);
        logic [31:0] base;
        base = addr & ~32'hF;
        for (int i = 0; i < LS; i++) exp_addr_q.push_back(base + 32'(4 * i));
        exp_line_q.push_back(mk_line(base));
        exp_base_q.push_back(base);
        n_issue = 0;
        bus.i_req_addr  = addr;
        bus.i_req_valid = 1'b1;
        check("accept_ready", 128'(bus.o_req_ready), 128'(1));
        step();
        if (!hold) bus.i_req_valid = 1'b0;
    endtask

    task automatic wait_line(output int n);
        logic [127:0] el;
        logic [31:0]  eb;
        n = 0;
        while (!bus.o_line_valid && n < 40) begin
            check("busy_req_ready", 128'(bus.o_req_ready), 128'(0));
            step();
            n++;
        end
        if (!bus.o_line_valid) begin
            check("line_timeout", 128'(bus.o_line_valid), 128'(1));
        end else if (exp_line_q.size() > 0) begin
            el = exp_line_q.pop_front();
            eb = exp_base_q.pop_front();
            check("line_data", 128'(bus.o_line_data), el);
            check("line_addr", 128'(bus.o_line_addr), 128'(eb));
            check("issue_count", 128'(n_issue), 128'(LS));
        end else begin
            check("unexpected_line", 128'(exp_line_q.size()), 128'(1));
        end
    endtask

    task automatic handshake();
        bus.i_line_ready = 1'b1;
        step();
        bus.i_line_ready = 1'b0;
        check("hs_line_valid", 128'(bus.o_line_valid), 128'(0));
        check("hs_req_ready", 128'(bus.o_req_ready), 128'(1));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, 128'(bus.o_req_ready), 128'(1));
        check({tag, "_mem_valid"}, 128'(bus.o_mem_valid), 128'(0));
        check({tag, "_mem_addr"}, 128'(bus.o_mem_addr), 128'(0));
        check({tag, "_line_valid"}, 128'(bus.o_line_valid), 128'(0));
        check({tag, "_line_addr"}, 128'(bus.o_line_addr), 128'(0));
        check({tag, "_line_data"}, 128'(bus.o_line_data), 128'(0));
    endtask

    initial begin
        int           n;
        logic [127:0] held;
        bus.i_req_addr   = '0;
        bus.i_req_valid  = 1'b0;
        bus.i_line_ready = 1'b0;
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rdata  = '0;
        bus.i_mem_rvalid = 1'b0;
        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;
        check_reset_vals("rst");

        // Single fill, zero-wait memory
        start(32'h1111_1001, 1'b0);
        check("t1_first_addr", 128'(bus.o_mem_addr), 128'(32'h1111_1000));
        for (int i = 0; i < LS; i++) begin
            check("t1_issue_run", 128'(bus.o_mem_valid), 128'(1));
            step();
        end
        wait_line(n);
        check("t1_latency", 128'(n + LS), 128'(5));
        handshake();

        // Memory backpressure
        start(32'h0000_4A38, 1'b0);
        rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        wait_line(n);
        handshake();

        // Variable latency and line backpressure
        var_lat = 1'b1;
        start(32'h0BAD_F00C, 1'b0);
        wait_line(n);
        held = mk_line(32'h0BAD_F000);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 128'(bus.o_line_valid), 128'(1));
            check("t3_hold_ready", 128'(bus.o_req_ready), 128'(0));
            check("t3_hold_data", 128'(bus.o_line_data), held);
            check("t3_hold_addr", 128'(bus.o_line_addr), 128'(32'h0BAD_F000));
            step();
        end
        handshake();
        var_lat = 1'b0;

        // Second request held high during a fill
        start(32'h3000_0104, 1'b1);
        bus.i_req_addr = 32'h2000_0010;
        wait_line(n);
        handshake();
        start(32'h2000_0010, 1'b0);
        wait_line(n);
        handshake();

        // Reset after two issues and one response, then a stray response
        start(32'h5555_0008, 1'b0);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        spur = 1'b1;
        step();
        spur = 1'b0;
        check_reset_vals("midrst");

        // Address wrap
        start(32'hFFFF_FFF4, 1'b0);
        wait_line(n);
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/kv_line_fill.md
# kv_line_fill

Line-fill engine between the KVCache fetch port and a word-wide memory read port. Accepts one line-fetch request at a time from the cache, issues LINE_SIZE sequential word reads with up to LINE_SIZE reads outstanding, and assembles the in-order responses into a line buffer. Presents the completed line back to the cache on a valid/ready handshake. It is the synthesizable replacement for the behavioural memory model on the cache's fetch side.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 32, byte address width
- LINE_SIZE, 4, words per line; power of two, at least 2
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req_addr  in  ADDR_WIDTH  byte address of the missing access; from the cache's o_fetch_addr
- i_req_valid  in  1  fetch request valid
- o_req_ready  out  1  request accepted when high together with i_req_valid
- o_line_data  out  DATA_WIDTH x LINE_SIZE  assembled line; element i holds word i; to the cache's i_fetch_data
- o_line_addr  out  ADDR_WIDTH  line-aligned base address of o_line_data
- o_line_valid  out  1  line complete
- i_line_ready  in  1  cache accepts the line
- o_mem_addr  out  ADDR_WIDTH  word read address, byte-addressed, 4-byte aligned
- o_mem_valid  out  1  read command valid
- i_mem_ready  in  1  memory accepts the read command
- i_mem_rdata  in  DATA_WIDTH  read data
- i_mem_rvalid  in  1  read data valid; responses return in issue order; no backpressure

## Operation
- Base = i_req_addr with the low log2(LINE_SIZE*4) bits cleared. Captured into o_line_addr on accept.
- Counters: issue_cnt and recv_cnt, each $clog2(LINE_SIZE)+1 bits wide. Both clear on accept.
- FSM has four states.
  - IDLE: o_req_ready=1. On i_req_valid, capture base, clear counters, go to FETCH.
  - FETCH: o_mem_valid=1 while issue_cnt<LINE_SIZE. o_mem_addr = base + 4*issue_cnt, truncated to ADDR_WIDTH. Each cycle with o_mem_valid && i_mem_ready increments issue_cnt. Each cycle with i_mem_rvalid writes i_mem_rdata into word[recv_cnt] and increments recv_cnt. Issue and receive may occur in the same cycle. When recv_cnt reaches LINE_SIZE, go to DONE.
  - DONE: o_line_valid=1. o_line_data and o_line_addr are stable. On i_line_ready, go to IDLE.
- o_mem_addr and o_mem_valid stay stable while o_mem_valid=1 and i_mem_ready=0.
- i_mem_rvalid outside FETCH, or when recv_cnt=LINE_SIZE, is ignored and not written.
- No request is accepted while a line is in flight or awaiting acceptance; o_req_ready=0 outside IDLE.
- o_line_data holds the last completed line until the next fill overwrites it word by word.

## Timing
- Reset values: state=IDLE, o_req_ready=1 (registered; high in the first cycle after reset), o_mem_valid=0, o_mem_addr=0, o_line_valid=0, o_line_addr=0, o_line_data all zero, both counters 0.
- Accept at edge T. o_mem_valid=1 with the base address in cycle T+1.
- Zero-wait memory (i_mem_ready=1, rdata returned one cycle after issue), LINE_SIZE=4:
  - issues in T+1..T+4
  - responses in T+2..T+5
  - o_line_valid=1 in T+6
- o_line_valid rises the cycle after the last response is written.
- Line handshake at edge D. o_line_valid=0 and o_req_ready=1 from D+1. Minimum back-to-back request spacing is therefore one IDLE cycle.
- i_rst high at any edge forces all reset values on the next cycle, including mid-FETCH with reads outstanding. Responses arriving after reset are dropped because the state is IDLE. The memory is reset by the same i_rst, so no stale responses follow a new accept.
- Address wrap: base + 4*i wraps modulo 2^ADDR_WIDTH; no carry out.

## Test plan
- Reset then single fill: i_req_addr=0x1111_1001, zero-wait memory with rdata = address -> o_mem_addr 0x1111_1000, 0x1111_1004, 0x1111_1008, 0x1111_100C in consecutive cycles; o_line_valid in T+6; o_line_data = {0x1111_100C, 0x1111_1008, 0x1111_1004, 0x1111_1000}; o_line_addr=0x1111_1000.
- Memory backpressure: i_mem_ready toggles 1,0,0,1,1,0,1 -> o_mem_addr held during stalls; exactly 4 issues; line correct.
- Variable response latency (0–3 idle cycles between rvalids) with i_line_ready=0 for 5 cycles after o_line_valid -> data and address held stable, o_req_ready=0 throughout; one cycle after the handshake, o_req_ready=1.
- Request during fill: i_req_valid held high for a second address 0x2000_0010 -> not accepted until after the first line handshake; second fill then issues 0x2000_0010..0x2000_001C.
- Reset mid-fill after 2 issues and 1 response, with a spurious i_mem_rvalid after reset -> all outputs at reset values; o_line_data unchanged (zero); o_req_ready=1.
- Wrap: i_req_addr=0xFFFF_FFF4 -> issues 0xFFFF_FFF0, 0xFFFF_FFF4, 0xFFFF_FFF8, 0xFFFF_FFFC; o_line_addr=0xFFFF_FFF0.
